// File: rtl/tpmem_pkg.sv
// Shared definitions for the NxN continuous-flow transpose memory.
//   state_e : controller states (EMPTY / STREAM / PAD / DRAIN)
//   element : extracts element k of an N-element packed row (element 0 at the MSB end)
package tpmem_pkg;

   typedef enum logic [1:0] {
      StEmpty,
      StStream,
      StPad,
      StDrain
   } state_e;

   // Widest element and row that element() can handle.
   localparam int unsigned MaxBw   = 64;
   localparam int unsigned MaxVecW = 4096;

   // Element k of an n-element row of bw-bit elements, zero-extended to MaxBw bits.
   function automatic logic [MaxBw-1:0] element(input logic [MaxVecW-1:0] vec,
                                                input int unsigned       k,
                                                input int unsigned       bw,
                                                input int unsigned       n);
      logic [MaxVecW-1:0] sh;
      logic [MaxBw-1:0]   mask;
      sh   = vec >> ((n - 1 - k) * bw);
      // For bw == MaxBw the shift yields 0 and the subtraction gives all ones.
      mask = (MaxBw'(1) << bw) - MaxBw'(1);
      return sh[MaxBw-1:0] & mask;
   endfunction

endpackage

// File: rtl/tpmem_ctrl.sv
// Controller for the transpose memory: FSM, slice index, write orientation and the
// "a complete block is stored" flag.
// Ports:
//   i_clk, i_Reset   clock; synchronous active-low reset
//   i_valid, i_flush input handshake and flush request
//   o_ready          input may be accepted (EMPTY/STREAM)
//   o_beat           active beat: accepted input, PAD cycle or DRAIN cycle
//   o_wr_en          slice is written this cycle (accepted input or PAD)
//   o_wr_zero        write data is all zeros (PAD)
//   o_full           a complete block is stored; beats produce output
//   o_orient         0: slice = row idx, 1: slice = column idx
//   o_idx            current slice index
module tpmem_ctrl
   import tpmem_pkg::*;
#(
   parameter  int unsigned N  = 8,
   localparam int unsigned LW = $clog2(N)
) (
   input  logic          i_clk,
   input  logic          i_Reset,
   input  logic          i_valid,
   input  logic          i_flush,
   output logic          o_ready,
   output logic          o_beat,
   output logic          o_wr_en,
   output logic          o_wr_zero,
   output logic          o_full,
   output logic          o_orient,
   output logic [LW-1:0] o_idx
);

   state_e        state_q, state_d;
   logic [LW-1:0] idx_q, idx_d;
   logic          orient_q, orient_d;
   logic          full_q, full_d;
   logic          accept;
   logic          wrap;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      orient_d = orient_q;
      full_d   = full_q;

      o_ready   = (state_q == StEmpty) || (state_q == StStream);
      accept    = o_ready & i_valid;
      o_wr_zero = (state_q == StPad);
      o_wr_en   = accept | o_wr_zero;
      o_beat    = o_wr_en | (state_q == StDrain);
      wrap      = o_beat && (idx_q == LW'(N - 1));

      if (o_beat) begin
         idx_d = wrap ? '0 : idx_q + LW'(1);
         if (wrap) begin
            orient_d = ~orient_q;
         end
      end
      if (wrap && o_wr_en) begin
         full_d = 1'b1;
      end
      if (wrap && (state_q == StDrain)) begin
         full_d = 1'b0;
      end

      unique case (state_q)
         StEmpty:  if (wrap) state_d = StStream;
         StStream: state_d = StStream;
         StPad:    if (wrap) state_d = StDrain;
         StDrain:  if (wrap) state_d = StEmpty;
         default:  state_d = StEmpty;
      endcase

      // Flush is judged on the post-beat position so a beat accepted together with the
      // flush is counted first.
      if (o_ready && i_flush) begin
         if (idx_d != '0) begin
            state_d = StPad;
         end else if (full_d) begin
            state_d = StDrain;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_Reset) begin
         state_q  <= StEmpty;
         idx_q    <= '0;
         orient_q <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         orient_q <= orient_d;
         full_q   <= full_d;
      end
   end

   assign o_full   = full_q;
   assign o_orient = orient_q;
   assign o_idx    = idx_q;

endmodule

// File: rtl/tpmem_nxn_stream.sv
// NxN continuous-flow transpose memory. Each active beat reads slice (idx, orient) of the
// store and overwrites it with the new row, so the previous block leaves transposed while
// the next block arrives; alternating orientation per block removes the need for a
// double buffer. i_flush zero-pads a partial block and drains the stored one.
// Ports:
//   i_clk, i_Reset    clock; synchronous active-low reset
//   i_valid, i_data   input row (element 0 at the MSB), accepted when i_valid & o_ready
//   i_flush           single-cycle pad-and-drain request
//   o_ready           combinational from controller state
//   o_valid, o_data   registered transposed row
//   o_last            registered; final row of an output block
module tpmem_nxn_stream
   import tpmem_pkg::*;
#(
   parameter  int unsigned BW = 10,
   parameter  int unsigned N  = 8,
   localparam int unsigned LW = $clog2(N)
) (
   input  logic            i_clk,
   input  logic            i_Reset,
   input  logic            i_valid,
   input  logic [N*BW-1:0] i_data,
   input  logic            i_flush,
   output logic            o_ready,
   output logic            o_valid,
   output logic [N*BW-1:0] o_data,
   output logic            o_last
);

   logic          beat, wr_en, wr_zero, full, orient;
   logic [LW-1:0] idx;

   tpmem_ctrl #(
      .N (N)
   ) u_ctrl (
      .i_clk     (i_clk),
      .i_Reset   (i_Reset),
      .i_valid   (i_valid),
      .i_flush   (i_flush),
      .o_ready   (o_ready),
      .o_beat    (beat),
      .o_wr_en   (wr_en),
      .o_wr_zero (wr_zero),
      .o_full    (full),
      .o_orient  (orient),
      .o_idx     (idx)
   );

   logic [BW-1:0]   mem_q [N][N];
   logic [BW-1:0]   mem_d [N][N];
   logic [BW-1:0]   wr_elem [N];
   logic [BW-1:0]   rd_elem [N];
   logic [N*BW-1:0] rd_row;

   for (genvar k = 0; k < N; k++) begin : g_slice
      assign wr_elem[k] = wr_zero ? '0 : BW'(element(MaxVecW'(i_data), k, BW, N));
      // Row idx in orientation 0, column idx in orientation 1.
      assign rd_elem[k] = orient ? mem_q[k][idx] : mem_q[idx][k];
      assign rd_row[(N-k)*BW-1 -: BW] = rd_elem[k];
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
               if (!orient && (LW'(r) == idx)) begin
                  mem_d[r][c] = wr_elem[c];
               end else if (orient && (LW'(c) == idx)) begin
                  mem_d[r][c] = wr_elem[r];
               end
            end
         end
      end
   end

   logic            o_valid_q, o_valid_d;
   logic            o_last_q, o_last_d;
   logic [N*BW-1:0] o_data_q, o_data_d;

   always_comb begin
      o_valid_d = beat & full;
      o_last_d  = beat & full & (idx == LW'(N - 1));
      o_data_d  = (beat & full) ? rd_row : o_data_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_Reset) begin
         mem_q     <= '{default: '0};
         o_valid_q <= 1'b0;
         o_last_q  <= 1'b0;
         o_data_q  <= '0;
      end else begin
         mem_q     <= mem_d;
         o_valid_q <= o_valid_d;
         o_last_q  <= o_last_d;
         o_data_q  <= o_data_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_last  = o_last_q;
   assign o_data  = o_data_q;

endmodule
